cmd_sequencer: RTL and testbench

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// Command sequencer: takes one 3-byte command from the UART wrapper,
// dispatches it to the execution unit and returns a one-byte response.
module cmd_sequencer #(
  parameter int unsigned TMO_CYC = 50000,
  parameter logic [7:0]  ACK     = 8'hA5,
  parameter logic [7:0]  NAK     = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic        exe_strt,
  output logic [7:0]  exe_op,
  output logic [15:0] exe_arg,
  input  logic        exe_done,
  input  logic        exe_err,
  output logic        snd_resp,
  output logic [7:0]  resp,
  input  logic        resp_sent,
  output logic        busy,
  output logic [7:0]  cmd_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DISP = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_SENT = 3'd4;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [7:0]  RSP_TMO  = 8'hE0;
  localparam logic [7:0]  RSP_ERR  = 8'hE1;

  logic [2:0]  state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] arg_q, arg_d;
  logic [7:0]  resp_q, resp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        opc_ok;

  // Opcodes 1..7 are executable; 0 and 8..F are rejected.
  assign opc_ok = (op_q[7:4] != 4'h0) && !op_q[7];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          op_d    = cmd;
          arg_d   = data;
          state_d = S_DISP;
        end
      end
      S_DISP: begin
        if (opc_ok) begin
          tmo_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          resp_d  = NAK;
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        // A completion in the last allowed cycle beats the timeout.
        if (exe_done) begin
          resp_d  = exe_err ? RSP_ERR : ACK;
          state_d = S_SEND;
        end else if (tmo_q == TMO_LAST) begin
          resp_d  = RSP_TMO;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_SENT;
      S_SENT: begin
        if (resp_sent) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 8'h00;
      arg_q   <= 16'h0000;
      resp_q  <= 8'h00;
      cnt_q   <= 8'h00;
      tmo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Gated by rst_n so the wrapper never sees a clear while in reset.
  assign clr_cmd_rdy = rst_n && (state_q == S_IDLE) && cmd_rdy;
  assign exe_strt    = (state_q == S_DISP) && opc_ok;
  assign snd_resp    = (state_q == S_SEND);
  assign busy        = (state_q != S_IDLE);
  assign exe_op      = op_q;
  assign exe_arg     = arg_q;
  assign resp        = resp_q;
  assign cmd_cnt     = cnt_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with TMO_CYC=8.
// Inputs change and outputs are checked on the falling edge.
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        exe_strt;
  logic [7:0]  exe_op;
  logic [15:0] exe_arg;
  logic        exe_done;
  logic        exe_err;
  logic        snd_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic        busy;
  logic [7:0]  cmd_cnt;

  int nvec = 0;
  int nerr = 0;

  cmd_sequencer #(.TMO_CYC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .exe_strt    (exe_strt),
    .exe_op      (exe_op),
    .exe_arg     (exe_arg),
    .exe_done    (exe_done),
    .exe_err     (exe_err),
    .snd_resp    (snd_resp),
    .resp        (resp),
    .resp_sent   (resp_sent),
    .busy        (busy),
    .cmd_cnt     (cmd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  // Full invalid-opcode command, starting in an IDLE low phase.
  task automatic run_nak(input logic [7:0] c);
    cmd = c; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0;
    adv();
    adv();
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0;
    exe_done = 1'b0; exe_err = 1'b0; resp_sent = 1'b0;
    adv(); adv();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_op", exe_op, 8'h00);
    chk("rst_arg", exe_arg, 16'h0000);
    chk("rst_resp", resp, 8'h00);
    chk("rst_cnt", cmd_cnt, 8'h00);
    adv();
    rst_n = 1'b1;

    // ACK path with 0x12 / BEEF
    adv();
    cmd = 8'h12; data = 16'hBEEF; cmd_rdy = 1'b1; #1;
    chk("t1_clr", clr_cmd_rdy, 1);
    adv();
    cmd_rdy = 1'b0; #1;
    chk("t1_strt", exe_strt, 1);
    chk("t1_op", exe_op, 8'h12);
    chk("t1_arg", exe_arg, 16'hBEEF);
    chk("t1_clr0", clr_cmd_rdy, 0);
    chk("t1_busy", busy, 1);
    adv();
    #1;
    chk("t1_strt0", exe_strt, 0);
    exe_done = 1'b1;
    adv();
    exe_done = 1'b0; #1;
    chk("t1_snd", snd_resp, 1);
    chk("t1_resp", resp, 8'hA5);
    adv();
    #1;
    chk("t1_snd0", snd_resp, 0);
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t1_cnt", cmd_cnt, 8'd1);
    chk("t1_idle", busy, 0);

    // invalid opcode 0x90
    cmd = 8'h90; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0; #1;
    chk("t2_nostrt", exe_strt, 0);
    chk("t2_nosnd", snd_resp, 0);
    adv();
    #1;
    chk("t2_snd", snd_resp, 1);
    chk("t2_resp", resp, 8'hEE);
    adv();
    exe_done = 1'b1; exe_err = 1'b1;
    adv();
    exe_done = 1'b0; exe_err = 1'b0; #1;
    chk("t2_ignore", resp, 8'hEE);
    chk("t2_hold", busy, 1);
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t2_cnt", cmd_cnt, 8'd2);

    // timeout after 8 WAIT_EXE cycles
    cmd = 8'h31; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0; #1;
    chk("t3_strt", exe_strt, 1);
    for (int i = 0; i < 8; i++) adv();
    #1;
    chk("t3_early", snd_resp, 0);
    adv();
    #1;
    chk("t3_snd", snd_resp, 1);
    chk("t3_resp", resp, 8'hE0);
    adv();
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0;

    // done in the final cycle wins over timeout
    cmd = 8'h32; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0;
    for (int i = 0; i < 8; i++) adv();
    exe_done = 1'b1;
    adv();
    exe_done = 1'b0; #1;
    chk("t3b_snd", snd_resp, 1);
    chk("t3b_resp", resp, 8'hA5);
    adv();
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t3b_cnt", cmd_cnt, 8'd4);

    // exe_err, plus a command queued during WAIT_SENT
    cmd = 8'h45; data = 16'h0001; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0;
    adv();
    exe_done = 1'b1; exe_err = 1'b1;
    adv();
    exe_done = 1'b0; exe_err = 1'b0; #1;
    chk("t4_resp", resp, 8'hE1);
    adv();
    cmd = 8'h56; data = 16'h1234; cmd_rdy = 1'b1; #1;
    chk("t4_noclr", clr_cmd_rdy, 0);
    chk("t4_op", exe_op, 8'h45);
    adv();
    #1;
    chk("t4_noclr2", clr_cmd_rdy, 0);
    chk("t4_wait", busy, 1);
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t4_clr", clr_cmd_rdy, 1);
    chk("t4_idle", busy, 0);
    chk("t4_cnt", cmd_cnt, 8'd5);
    adv();
    cmd_rdy = 1'b0; #1;
    chk("t4_strt", exe_strt, 1);
    chk("t4_op2", exe_op, 8'h56);
    chk("t4_arg2", exe_arg, 16'h1234);
    adv();
    exe_done = 1'b1;
    adv();
    exe_done = 1'b0; #1;
    chk("t4_resp2", resp, 8'hA5);
    adv();
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t4_cnt2", cmd_cnt, 8'd6);

    // reset in WAIT_EXE with a pending command
    cmd = 8'h27; data = 16'hAAAA; cmd_rdy = 1'b1;
    adv();
    cmd_rdy = 1'b0;
    adv();
    cmd = 8'h13; data = 16'h5555; cmd_rdy = 1'b1;
    rst_n = 1'b0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_op", exe_op, 8'h00);
    chk("t5_arg", exe_arg, 16'h0000);
    chk("t5_resp", resp, 8'h00);
    chk("t5_cnt", cmd_cnt, 8'h00);
    chk("t5_clr", clr_cmd_rdy, 0);
    chk("t5_snd", snd_resp, 0);
    exe_done = 1'b1;
    adv();
    exe_done = 1'b0; #1;
    chk("t5_snd2", snd_resp, 0);
    rst_n = 1'b1; #1;
    chk("t5_svc", clr_cmd_rdy, 1);
    adv();
    cmd_rdy = 1'b0; #1;
    chk("t5_strt", exe_strt, 1);
    chk("t5_op2", exe_op, 8'h13);
    adv();
    exe_done = 1'b1;
    adv();
    exe_done = 1'b0;
    adv();
    resp_sent = 1'b1;
    adv();
    resp_sent = 1'b0; #1;
    chk("t5_cnt2", cmd_cnt, 8'd1);

    // counter wrap
    for (int i = 0; i < 254; i++) run_nak(8'hF0);
    #1;
    chk("t6_ff", cmd_cnt, 8'hFF);
    run_nak(8'h00);
    #1;
    chk("t6_wrap", cmd_cnt, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
